pkt_cfg_parser: RTL and testbench
=================================

PKT_CFG_PARSER -- requirements
Module: pkt_cfg_parser

Interface
REQ-001 Parameter NUM_CH, default 4: number of configuration channels, range 1..16.
REQ-002 Parameter PAYLOAD_BYTES, default 10: payload bytes per packet, range 1..32.
REQ-003 Parameter HEADER, default 8'h55: start-of-packet byte.
REQ-004 Parameter TAIL, default 8'hAA: end-of-packet byte.
REQ-005 Parameter TIMEOUT_CYCLES, default 50000: maximum idle sys_clk cycles allowed between bytes inside a packet.
REQ-006 sys_clk  input  1  single clock; all logic is rising-edge.
REQ-007 sys_rst  input  1  synchronous, active-high reset.
REQ-008 rx_data  input  8  byte from the UART receiver.
REQ-009 rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-010 cfg_data  output  NUM_CH*PAYLOAD_BYTES*8  flattened per-channel config; channel k occupies slice [k*P*8 +: P*8], where P = PAYLOAD_BYTES.
REQ-011 cfg_update  output  NUM_CH  one-cycle pulse per channel when that channel's slice changes.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 err_chan, err_chk, err_tail, err_timeout  output  1 each  one-cycle error pulses.
REQ-014 pkt_cnt  output  16  count of accepted packets.

Function
REQ-015 The frame SHALL be HEADER, CH, PAYLOAD_BYTES payload bytes, CHK, TAIL, where CHK = XOR of CH and all payload bytes.
REQ-016 The FSM SHALL have five states: IDLE, CHAN, PAYLOAD, CHECK and TAILW. Every transition SHALL occur only on a cycle with rx_valid=1, except the timeout transition.
REQ-017 In IDLE, a byte equal to HEADER SHALL move the FSM to CHAN. Any other byte SHALL be discarded silently, with no error pulse.
REQ-018 In CHAN:
- CH < NUM_CH: latch CH, clear the byte index and the running XOR, seed the XOR with CH, and go to PAYLOAD.
- CH >= NUM_CH: pulse err_chan and go to IDLE.
REQ-019 In PAYLOAD, byte i (0-based) SHALL be written to shadow bits [i*8 +: 8], so the first byte is least significant. It SHALL also be XORed into the running XOR. After byte PAYLOAD_BYTES-1 the FSM SHALL go to CHECK.
REQ-020 In CHECK:
- Byte equal to the running XOR: go to TAILW.
- Otherwise: pulse err_chk and go to IDLE.
REQ-021 In TAILW:
- Byte equal to TAIL: copy the shadow register into the latched channel's slice, go to IDLE.
- Otherwise: pulse err_tail, go to IDLE, and leave cfg_data unchanged.
REQ-022 Commit latency: the cfg_data slice update and cfg_update[CH] SHALL both be visible in the cycle after the accepted TAIL strobe. Only bit CH of cfg_update SHALL pulse.
REQ-023 pkt_cnt SHALL increment by 1 on each commit and SHALL wrap from 16'hFFFF to 0.
REQ-024 Timeout counter behaviour:
- Clears on every rx_valid.
- Increments each cycle while the FSM is not in IDLE.
- On reaching TIMEOUT_CYCLES: pulse err_timeout, go to IDLE, and discard the shadow data.
- A byte strobed in the same cycle that the timeout fires SHALL be ignored.
REQ-025 Rejected packets SHALL NOT modify cfg_data, cfg_update or pkt_cnt.
REQ-026 A HEADER value appearing as CH, payload, CHK or TAIL SHALL be treated as data; there is no mid-packet resynchronisation.
REQ-027 The shadow register SHALL be separate from cfg_data, so a partial packet is never visible on the outputs.

Reset
REQ-028 While sys_rst=1 at a clock edge, the block SHALL return to its reset state:
- State IDLE.
- cfg_data = 0 and shadow = 0.
- cfg_update, all err_* outputs and busy = 0.
- pkt_cnt = 0; timeout counter, byte index and running XOR = 0.
REQ-029 rx_valid SHALL be ignored in any cycle where sys_rst=1.
REQ-030 A reset asserted mid-packet SHALL abort the packet with no error pulse and no commit.

Verification
REQ-031 Good packet: 55 01 11 12 13 14 15 16 17 18 19 1A 0A AA.
- Next cycle: cfg_update = 4'b0010.
- Channel 1 slice = 80'h1A191817161514131211.
- pkt_cnt = 1.
REQ-032 Bad checksum: the REQ-031 packet with CHK = 0B.
- err_chk pulses once, on the CHK byte.
- cfg_data unchanged, pkt_cnt unchanged.
REQ-033 Bad channel, then a good packet: 55 07 ..., immediately followed by a good packet on channel 3.
- err_chan pulses once, on the CH byte.
- Channel 3 then commits normally.
REQ-034 Bad tail and leading garbage:
- Valid frame ending in 55 instead of AA: err_tail pulses, no commit.
- Bytes 00 FF 12 sent in IDLE: no error pulses and no state change.
REQ-035 Timeout: send 55 02 03, then TIMEOUT_CYCLES idle cycles.
- err_timeout pulses once and busy falls.
- A following good packet commits.
REQ-036 Reset and wrap:
- sys_rst asserted after 5 payload bytes: no commit.
- A good packet after reset release: accepted.
- With pkt_cnt preloaded via 65536 packets, the count wraps to 0.

Source files
------------

// File: rtl/pkt_cfg_parser.sv
// Byte-stream configuration parser: HEADER, CH, payload, CHK, TAIL framing.
// Validated payloads are committed atomically into per-channel config slices.
module pkt_cfg_parser #(
    parameter int         NUM_CH         = 4,
    parameter int         PAYLOAD_BYTES  = 10,
    parameter logic [7:0] HEADER         = 8'h55,
    parameter logic [7:0] TAIL           = 8'hAA,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic                              sys_clk,
    input  logic                              sys_rst,
    input  logic [7:0]                        rx_data,
    input  logic                              rx_valid,
    output logic [NUM_CH*PAYLOAD_BYTES*8-1:0] cfg_data,
    output logic [NUM_CH-1:0]                 cfg_update,
    output logic                              busy,
    output logic                              err_chan,
    output logic                              err_chk,
    output logic                              err_tail,
    output logic                              err_timeout,
    output logic [15:0]                       pkt_cnt
);

    localparam int PW = PAYLOAD_BYTES * 8;
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IW = $clog2(PAYLOAD_BYTES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]    NCH  = 8'(NUM_CH);
    localparam logic [IW-1:0] LAST = IW'(PAYLOAD_BYTES - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE, CHAN, PAYLOAD, CHECK, TAILW
    } state_t;

    state_t                   r_state;
    logic [CW-1:0]            r_ch;
    logic [IW-1:0]            r_idx;
    logic [7:0]               r_xor;
    logic [PW-1:0]            r_shadow;
    logic [NUM_CH*PW-1:0]     r_cfg;
    logic [NUM_CH-1:0]        r_upd;
    logic                     r_err_chan;
    logic                     r_err_chk;
    logic                     r_err_tail;
    logic                     r_err_to;
    logic [15:0]              r_pkt_cnt;
    logic [TW-1:0]            r_to;
    logic                     w_to_fire;

    assign w_to_fire = (r_state != IDLE) && (r_to == TMAX);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= IDLE;
            r_ch       <= '0;
            r_idx      <= '0;
            r_xor      <= '0;
            r_shadow   <= '0;
            r_cfg      <= '0;
            r_upd      <= '0;
            r_err_chan <= 1'b0;
            r_err_chk  <= 1'b0;
            r_err_tail <= 1'b0;
            r_err_to   <= 1'b0;
            r_pkt_cnt  <= '0;
            r_to       <= '0;
        end else begin
            r_upd      <= '0;
            r_err_chan <= 1'b0;
            r_err_chk  <= 1'b0;
            r_err_tail <= 1'b0;
            r_err_to   <= 1'b0;
            if (rx_valid || r_state == IDLE)
                r_to <= '0;
            else
                r_to <= r_to + TW'(1);

            // Timeout wins over a byte arriving in the same cycle.
            if (w_to_fire) begin
                r_err_to <= 1'b1;
                r_state  <= IDLE;
                r_shadow <= '0;
            end else if (rx_valid) begin
                unique case (r_state)
                    IDLE: begin
                        if (rx_data == HEADER)
                            r_state <= CHAN;
                    end
                    CHAN: begin
                        if (rx_data < NCH) begin
                            r_ch    <= rx_data[CW-1:0];
                            r_idx   <= '0;
                            r_xor   <= rx_data;
                            r_state <= PAYLOAD;
                        end else begin
                            r_err_chan <= 1'b1;
                            r_state    <= IDLE;
                        end
                    end
                    PAYLOAD: begin
                        r_shadow[r_idx*8 +: 8] <= rx_data;
                        r_xor <= r_xor ^ rx_data;
                        r_idx <= r_idx + IW'(1);
                        if (r_idx == LAST)
                            r_state <= CHECK;
                    end
                    CHECK: begin
                        if (rx_data == r_xor) begin
                            r_state <= TAILW;
                        end else begin
                            r_err_chk <= 1'b1;
                            r_state   <= IDLE;
                        end
                    end
                    TAILW: begin
                        if (rx_data == TAIL) begin
                            r_cfg[r_ch*PW +: PW] <= r_shadow;
                            r_upd[r_ch]          <= 1'b1;
                            r_pkt_cnt            <= r_pkt_cnt + 16'd1;
                        end else begin
                            r_err_tail <= 1'b1;
                        end
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign cfg_data    = r_cfg;
    assign cfg_update  = r_upd;
    assign busy        = (r_state != IDLE);
    assign err_chan    = r_err_chan;
    assign err_chk     = r_err_chk;
    assign err_tail    = r_err_tail;
    assign err_timeout = r_err_to;
    assign pkt_cnt     = r_pkt_cnt;

endmodule

// File: tb/tb_pkt_cfg_parser.sv
// Directed bench for pkt_cfg_parser: framing, errors, timeout, reset, wrap.
module tb_pkt_cfg_parser;

    localparam int NCH = 4;
    localparam int PB  = 10;
    localparam int TO  = 40;
    localparam int PW  = PB * 8;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic [NCH*PW-1:0] cfg_data;
    logic [NCH-1:0]    cfg_update;
    logic              busy;
    logic              err_chan, err_chk, err_tail, err_timeout;
    logic [15:0]       pkt_cnt;

    int checks = 0;
    int errors = 0;
    int n_chan = 0, n_chk = 0, n_tail = 0, n_to = 0, n_upd = 0;

    logic [NCH*PW-1:0] exp_cfg;
    logic [PW-1:0]     pl_a, pl_b, pl_c;

    pkt_cfg_parser #(
        .NUM_CH(NCH), .PAYLOAD_BYTES(PB), .HEADER(8'h55),
        .TAIL(8'hAA), .TIMEOUT_CYCLES(TO)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .cfg_data(cfg_data), .cfg_update(cfg_update), .busy(busy),
        .err_chan(err_chan), .err_chk(err_chk), .err_tail(err_tail),
        .err_timeout(err_timeout), .pkt_cnt(pkt_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (err_chan)    n_chan++;
        if (err_chk)     n_chk++;
        if (err_tail)    n_tail++;
        if (err_timeout) n_to++;
        if (cfg_update != '0) n_upd++;
    end

    task automatic check(input string tag, input logic [NCH*PW-1:0] obs,
                         input logic [NCH*PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge sys_clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_body(input logic [7:0] ch, input logic [PW-1:0] pl);
        send(8'h55);
        send(ch);
        for (int i = 0; i < PB; i++) send(pl[i*8 +: 8]);
    endtask

    initial begin
        pl_a = 80'h1A191817161514131211;
        pl_b = 80'h0A090807060504030201;
        pl_c = {10{8'h55}};
        exp_cfg = '0;

        idle(3);
        sys_rst = 1'b0;
        check("rst_cfg", cfg_data, '0);
        check("rst_upd", cfg_update, '0);
        check("rst_busy", busy, 0);
        check("rst_cnt", pkt_cnt, 0);
        check("rst_err", {err_chan, err_chk, err_tail, err_timeout}, 0);

        send(8'h55);
        send(8'h01);
        check("busy_in_pkt", busy, 1);
        for (int i = 0; i < PB; i++) send(pl_a[i*8 +: 8]);
        send(8'h0A);
        check("no_partial", cfg_data, '0);
        send(8'hAA);
        exp_cfg[1*PW +: PW] = pl_a;
        check("good_upd", cfg_update, 4'b0010);
        check("good_cfg", cfg_data, exp_cfg);
        check("good_cnt", pkt_cnt, 1);
        idle(1);
        check("upd_one_cycle", cfg_update, 0);
        check("idle_after", busy, 0);

        send_body(8'h01, pl_a);
        send(8'h0B);
        check("chk_pulse", err_chk, 1);
        send(8'hAA);
        idle(1);
        check("chk_count", n_chk, 1);
        check("chk_cfg", cfg_data, exp_cfg);
        check("chk_cnt", pkt_cnt, 1);

        send(8'h55);
        send(8'h07);
        check("chan_pulse", err_chan, 1);
        send_body(8'h03, pl_b);
        send(8'h08);
        send(8'hAA);
        exp_cfg[3*PW +: PW] = pl_b;
        check("ch3_upd", cfg_update, 4'b1000);
        check("ch3_cfg", cfg_data, exp_cfg);
        check("ch3_cnt", pkt_cnt, 2);
        check("chan_count", n_chan, 1);

        send_body(8'h00, pl_c);
        send(8'h00);
        send(8'h55);
        check("tail_pulse", err_tail, 1);
        idle(1);
        check("tail_cfg", cfg_data, exp_cfg);
        check("tail_cnt", pkt_cnt, 2);
        send(8'h00);
        send(8'hFF);
        send(8'h12);
        idle(1);
        check("garbage_busy", busy, 0);
        check("garbage_err", {n_chan, n_chk, n_tail, n_to}, {32'd1, 32'd1, 32'd1, 32'd0});
        send_body(8'h00, pl_c);
        send(8'h00);
        send(8'hAA);
        exp_cfg[0*PW +: PW] = pl_c;
        check("hdr_as_data", cfg_data, exp_cfg);
        check("hdr_cnt", pkt_cnt, 3);

        send(8'h55);
        send(8'h02);
        send(8'h03);
        idle(TO - 1);
        check("to_not_early", busy, 1);
        begin
            int waited = 0;
            while (!err_timeout && waited < 10) begin
                idle(1);
                waited++;
            end
            check("to_pulse", err_timeout, 1);
        end
        check("to_busy", busy, 0);
        idle(2);
        check("to_count", n_to, 1);
        send_body(8'h02, pl_a);
        send(8'h09);
        send(8'hAA);
        exp_cfg[2*PW +: PW] = pl_a;
        check("to_next_cfg", cfg_data, exp_cfg);
        check("to_next_cnt", pkt_cnt, 4);

        send(8'h55);
        send(8'h01);
        for (int i = 0; i < 5; i++) send(pl_b[i*8 +: 8]);
        sys_rst  = 1'b1;
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        idle(2);
        rx_valid = 1'b0;
        sys_rst  = 1'b0;
        check("mid_rst_cfg", cfg_data, '0);
        check("mid_rst_cnt", pkt_cnt, 0);
        check("mid_rst_busy", busy, 0);
        for (int i = 5; i < PB; i++) send(pl_b[i*8 +: 8]);
        idle(1);
        check("mid_rst_noerr", {n_chan, n_chk, n_tail, n_to, n_upd},
              {32'd1, 32'd1, 32'd1, 32'd1, 32'd4});
        exp_cfg = '0;
        send_body(8'h01, pl_a);
        send(8'h0A);
        send(8'hAA);
        exp_cfg[1*PW +: PW] = pl_a;
        check("post_rst_cfg", cfg_data, exp_cfg);
        check("post_rst_cnt", pkt_cnt, 1);

        force dut.r_pkt_cnt = 16'hFFFF;
        #1;
        release dut.r_pkt_cnt;
        idle(1);
        check("preload_cnt", pkt_cnt, 16'hFFFF);
        send_body(8'h03, pl_b);
        send(8'h08);
        send(8'hAA);
        check("wrap_cnt", pkt_cnt, 0);
        check("wrap_upd", cfg_update, 4'b1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
